crc8_frame_serializer: RTL and testbench

- Upstream stage of the CRC8 bit-serial checksum unit.
- Accepts payload bytes over a valid/ready handshake and shifts each byte out MSB-first as a serial bit stream.
- Drives the CRC8 unit's BITVAL, BITSTRB, ENABLE and CLEAR inputs.
- After the last payload byte, latches the CRC8 result and appends it MSB-first as the frame trailer.

---
 rtl/crc8_frame_serializer.sv | 145 ++++++++++++++
 tb/tb_crc8_frame_serializer.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/crc8_frame_serializer.sv
// Byte-to-bit serializer feeding a bit-serial CRC8 unit: shifts payload bytes
// out MSB-first, then appends the latched CRC8 result as an 8-bit trailer.
`timescale 1ns/1ps
module crc8_frame_serializer #(
  parameter int BIT_DIV = 4
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [7:0] DIN,
  input  logic       DIN_VALID,
  input  logic       DIN_LAST,
  output logic       DIN_READY,
  output logic       SER_OUT,
  output logic       SER_STRB,
  output logic       BITVAL,
  output logic       BITSTRB,
  output logic       CRC_ENABLE,
  output logic       CRC_CLEAR,
  input  logic [7:0] CRC_IN,
  output logic       BUSY,
  output logic       FRAME_DONE
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLR,
    S_DATA,
    S_LOAD,
    S_CRC_WAIT,
    S_CRC_SEND,
    S_DONE
  } state_t;

  localparam logic [7:0] PH_STRB = 8'(BIT_DIV / 2);
  localparam logic [7:0] PH_LAST = 8'(BIT_DIV - 1);

  state_t     state, state_nxt;
  logic [7:0] phase, phase_nxt;
  logic [2:0] bitcnt, bitcnt_nxt;
  logic       crc_clear_q;
  logic [7:0] shreg;
  logic       last_flag;

  logic       in_bits;
  logic       bit_end;
  logic       strb;
  logic       xfer;
  logic       ld_din;
  logic       ld_crc;
  logic       shift_en;

  assign in_bits = (state == S_DATA) || (state == S_CRC_SEND);
  assign bit_end = in_bits && (phase == PH_LAST);
  assign strb    = in_bits && (phase == PH_STRB);
  assign xfer    = DIN_VALID && DIN_READY;

  // Phase and bit counters always come back to zero at the end of a byte,
  // so every byte (payload or trailer) starts on a clean bit period.
  always_comb begin
    state_nxt  = state;
    phase_nxt  = phase;
    bitcnt_nxt = bitcnt;
    ld_din     = 1'b0;
    ld_crc     = 1'b0;
    shift_en   = 1'b0;

    if (in_bits) begin
      if (bit_end) begin
        phase_nxt  = 8'd0;
        shift_en   = 1'b1;
        bitcnt_nxt = bitcnt + 3'd1;
      end else begin
        phase_nxt = phase + 8'd1;
      end
    end

    case (state)
      S_IDLE: begin
        if (xfer) begin
          ld_din    = 1'b1;
          state_nxt = S_CLR;
        end
      end
      S_CLR: state_nxt = S_DATA;
      S_DATA: begin
        if (bit_end && (bitcnt == 3'd7))
          state_nxt = last_flag ? S_CRC_WAIT : S_LOAD;
      end
      S_LOAD: begin
        if (xfer) begin
          ld_din    = 1'b1;
          state_nxt = S_DATA;
        end
      end
      S_CRC_WAIT: begin
        ld_crc    = 1'b1;
        state_nxt = S_CRC_SEND;
      end
      S_CRC_SEND: begin
        if (bit_end && (bitcnt == 3'd7))
          state_nxt = S_DONE;
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Control state: the only registers touched by reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state       <= S_IDLE;
      phase       <= 8'd0;
      bitcnt      <= 3'd0;
      crc_clear_q <= 1'b1;
    end else begin
      state       <= state_nxt;
      phase       <= phase_nxt;
      bitcnt      <= bitcnt_nxt;
      crc_clear_q <= (state_nxt == S_CLR);
    end
  end

  // Datapath: shift register is only observed while a bit period is active.
  always_ff @(posedge CLK) begin
    if (ld_din) begin
      shreg     <= DIN;
      last_flag <= DIN_LAST;
    end else if (ld_crc) begin
      shreg <= CRC_IN;
    end else if (shift_en) begin
      shreg <= {shreg[6:0], 1'b0};
    end
  end

  assign DIN_READY  = (state == S_IDLE) || (state == S_LOAD);
  assign SER_OUT    = in_bits && shreg[7];
  assign BITVAL     = SER_OUT;
  assign SER_STRB   = strb;
  assign BITSTRB    = strb && (state == S_DATA);
  assign CRC_ENABLE = (state == S_DATA) || (state == S_LOAD);
  assign CRC_CLEAR  = crc_clear_q;
  assign BUSY       = (state != S_IDLE);
  assign FRAME_DONE = (state == S_DONE);

endmodule

// File: tb/tb_crc8_frame_serializer.sv
// Bench for crc8_frame_serializer: three instances (BIT_DIV 4, 2, 7), each with
// an attached bit-serial CRC8 (poly 0xD5) device model; trailers checked against constants or polynomial division.
`timescale 1ns/1ps
module tb_crc8_frame_serializer;

  typedef logic [7:0] byte_q_t[$];

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b1;
  logic [7:0] din = 8'd0;
  logic       din_valid = 1'b0;
  logic       din_last = 1'b0;
  int         sel = 0;

  logic [2:0] din_ready, ser_out, ser_strb, bitval, bitstrb, crc_en, crc_clr, busy, fdone;
  logic [7:0] crc_in [3];

  int total = 0;
  int bad = 0;

  for (genvar g = 0; g < 3; g++) begin : gi
    localparam int BD = (g == 0) ? 4 : ((g == 1) ? 2 : 7);
    logic       vld;
    logic [7:0] crc_q;
    assign vld = din_valid && (sel == g);
    crc8_frame_serializer #(.BIT_DIV(BD)) dut (
      .CLK(clk), .RST(rst), .DIN(din), .DIN_VALID(vld), .DIN_LAST(din_last),
      .DIN_READY(din_ready[g]), .SER_OUT(ser_out[g]), .SER_STRB(ser_strb[g]),
      .BITVAL(bitval[g]), .BITSTRB(bitstrb[g]), .CRC_ENABLE(crc_en[g]),
      .CRC_CLEAR(crc_clr[g]), .CRC_IN(crc_q), .BUSY(busy[g]), .FRAME_DONE(fdone[g])
    );
    always @(posedge clk) begin
      if (crc_clr[g]) crc_q <= 8'h00;
      else if (crc_en[g] && bitstrb[g])
        crc_q <= {crc_q[6:0], 1'b0} ^ (((crc_q[7] ^ bitval[g]) == 1'b1) ? 8'hD5 : 8'h00);
    end
    assign crc_in[g] = crc_q;
  end

  // Remainder of message * x^8 divided by x^8+x^7+x^6+x^4+x^2+1.
  function automatic logic [7:0] crc_ref(input byte_q_t bytes);
    logic       bits[$];
    logic [8:0] p;
    logic [7:0] r;
    p = 9'h1D5;
    foreach (bytes[b]) for (int i = 7; i >= 0; i--) bits.push_back(bytes[b][i]);
    for (int i = 0; i < 8; i++) bits.push_back(1'b0);
    for (int i = 0; i + 8 < bits.size(); i++)
      if (bits[i]) for (int j = 0; j < 9; j++) bits[i+j] = bits[i+j] ^ p[8-j];
    for (int i = 0; i < 8; i++) r[7-i] = bits[bits.size()-8+i];
    return r;
  endfunction

  function automatic byte_q_t mk(input int n, input logic [31:0] v);
    byte_q_t q;
    for (int i = n - 1; i >= 0; i--) q.push_back(v[i*8 +: 8]);
    return q;
  endfunction

  task automatic run_frame(input int s, input int d, input byte_q_t bytes, input int gap,
                           input int abort_at, input int exp_trl, input string name);
    logic bits[$];
    int   n, k, idx, gapcnt, nstrb, nbit, ndone, viol, loadrdy, acc0, clr_at, first_strb, done_at, mm;
    logic xfer;
    logic [7:0] trl, want;
    n = bytes.size(); k = 0; idx = 0; gapcnt = 0; nstrb = 0; nbit = 0; ndone = 0;
    viol = 0; loadrdy = 0; acc0 = -1; clr_at = -1; first_strb = -1; done_at = -1;
    @(posedge clk); #1;
    sel = s; din = bytes[0]; din_last = (n == 1); din_valid = 1'b1;
    forever begin
      @(negedge clk); k++;
      if (k > 4000) begin
        total++; bad++;
        $display("FAIL %s timeout: %0d cycles without FRAME_DONE, required fewer than 4000", name, k);
        din_valid = 1'b0;
        return;
      end
      if (done_at >= 0) begin
        if (busy[s] !== 1'b0) viol++;
        break;
      end
      if (ser_strb[s]) begin
        bits.push_back(ser_out[s]);
        nstrb++;
        if (first_strb < 0) first_strb = k;
      end
      if (bitstrb[s]) begin
        nbit++;
        if (!ser_strb[s] || !crc_en[s] || crc_clr[s]) viol++;
      end
      if (busy[s] && din_ready[s]) begin
        loadrdy++;
        if (ser_out[s] || ser_strb[s] || !crc_en[s]) viol++;
      end
      if (crc_clr[s] && acc0 >= 0 && clr_at < 0) clr_at = k;
      if (fdone[s]) begin
        ndone++; done_at = k;
        if (ser_out[s] !== 1'b0) viol++;
      end
      if (abort_at > 0 && nstrb >= abort_at) begin
        din_valid = 1'b0;
        return;
      end
      xfer = din_valid && din_ready[s];
      if (xfer && acc0 < 0) acc0 = k;
      @(posedge clk); #1;
      if (xfer) begin
        idx++;
        if (idx < n) begin
          din = bytes[idx]; din_last = (idx == n - 1);
          if (gap > 0) begin din_valid = 1'b0; gapcnt = gap; end
        end else din_valid = 1'b0;
      end else if (gapcnt > 0) begin
        gapcnt--;
        if (gapcnt == 0) din_valid = 1'b1;
      end
    end

    total++;
    if (nstrb !== 8*n + 8) begin bad++; $display("FAIL %s ser_strb count: got %0d, required %0d", name, nstrb, 8*n+8); end
    total++;
    if (nbit !== 8*n) begin bad++; $display("FAIL %s bitstrb count: got %0d, required %0d", name, nbit, 8*n); end
    mm = 0;
    for (int b = 0; b < n; b++)
      for (int i = 0; i < 8; i++)
        if (b*8 + i >= bits.size() || bits[b*8+i] !== bytes[b][7-i]) mm++;
    total++;
    if (mm !== 0) begin bad++; $display("FAIL %s payload bits: %0d wrong, required 0", name, mm); end
    trl = 8'hxx;
    if (bits.size() >= 8*n + 8) for (int i = 0; i < 8; i++) trl[7-i] = bits[8*n+i];
    want = (exp_trl >= 0) ? 8'(exp_trl) : crc_ref(bytes);
    total++;
    if (trl !== want) begin bad++; $display("FAIL %s trailer: got %02h, required %02h", name, trl, want); end
    total++;
    if (clr_at !== acc0 + 1) begin bad++; $display("FAIL %s crc_clear cycle: got %0d, required %0d", name, clr_at, acc0+1); end
    total++;
    if (first_strb !== acc0 + 2 + d/2) begin bad++; $display("FAIL %s first strobe cycle: got %0d, required %0d", name, first_strb, acc0+2+d/2); end
    total++;
    if (ndone !== 1) begin bad++; $display("FAIL %s frame_done pulses: got %0d, required 1", name, ndone); end
    total++;
    if (viol !== 0) begin bad++; $display("FAIL %s protocol violations: got %0d, required 0", name, viol); end
    if (gap == 0) begin
      total++;
      if (done_at - acc0 !== n*8*d + (n-1) + 8*d + 3) begin
        bad++; $display("FAIL %s frame length: got %0d, required %0d", name, done_at-acc0+1, n*8*d+(n-1)+8*d+4);
      end
      total++;
      if (loadrdy !== n - 1) begin bad++; $display("FAIL %s load ready cycles: got %0d, required %0d", name, loadrdy, n-1); end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; din_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++;
    if ({ser_out, ser_strb, bitstrb, crc_en, busy, fdone} !== 18'd0) begin
      bad++; $display("FAIL reset outputs: got %05h, required 00000", {ser_out, ser_strb, bitstrb, crc_en, busy, fdone});
    end
    total++;
    if (crc_clr !== 3'b111) begin bad++; $display("FAIL reset crc_clear: got %b, required 111", crc_clr); end
    total++;
    if (din_ready !== 3'b111) begin bad++; $display("FAIL reset din_ready: got %b, required 111", din_ready); end
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    total++;
    if (crc_clr !== 3'b111) begin bad++; $display("FAIL clear after reset: got %b, required 111", crc_clr); end
    @(negedge clk);
    total++;
    if (crc_clr !== 3'b000) begin bad++; $display("FAIL clear drop: got %b, required 000", crc_clr); end
  endtask

  task automatic test_single();
    run_frame(0, 4, mk(1, 32'h01), 0, 0, 8'hD5, "single_01");
    run_frame(0, 4, mk(1, 32'h80), 0, 0, 8'hEF, "single_80");
    run_frame(0, 4, mk(1, 32'h00), 0, 0, 8'h00, "single_00");
  endtask

  task automatic test_back_to_back();
    run_frame(0, 4, mk(2, 32'h0100), 0, 0, 8'h0B, "b2b_01_00");
  endtask

  task automatic test_gap();
    run_frame(0, 4, mk(2, 32'h0100), 20, 0, 8'h0B, "gap_01_00");
  endtask

  task automatic test_mid_reset();
    int nd;
    run_frame(0, 4, mk(1, 32'h01), 0, 12, 8'hD5, "mid_reset");
    rst = 1'b1;
    @(negedge clk);
    total++;
    if ({busy[0], ser_out[0], ser_strb[0], fdone[0], crc_en[0]} !== 5'b00000) begin
      bad++; $display("FAIL mid_reset outputs: got %b, required 00000", {busy[0], ser_out[0], ser_strb[0], fdone[0], crc_en[0]});
    end
    total++;
    if (crc_clr[0] !== 1'b1) begin bad++; $display("FAIL mid_reset crc_clear: got %b, required 1", crc_clr[0]); end
    rst = 1'b0;
    nd = 0;
    repeat (40) begin @(negedge clk); if (fdone[0] || busy[0]) nd++; end
    total++;
    if (nd !== 0) begin bad++; $display("FAIL mid_reset aborted frame activity: got %0d cycles, required 0", nd); end
    run_frame(0, 4, mk(1, 32'h01), 0, 0, 8'hD5, "after_reset_01");
  endtask

  task automatic test_bit_div();
    run_frame(1, 2, mk(1, 32'h80), 0, 0, 8'hEF, "div2_80");
    run_frame(2, 7, mk(1, 32'h80), 0, 0, 8'hEF, "div7_80");
  endtask

  task automatic test_random();
    for (int t = 0; t < 8; t++) begin
      int s, d, n, gap;
      s = $urandom_range(0, 2);
      d = (s == 0) ? 4 : ((s == 1) ? 2 : 7);
      n = $urandom_range(1, 4);
      gap = ($urandom_range(0, 1) == 1) ? $urandom_range(1, 12) : 0;
      run_frame(s, d, mk(n, $urandom), gap, 0, -1, $sformatf("random_%0d", t));
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_gap();
    test_mid_reset();
    test_bit_div();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
